mem_wb_pipeline: RTL and testbench
==================================

# mem_wb_pipeline

Holds the EX/MEM and MEM/WB pipeline registers of the pipelined core and sequences data-memory accesses in the MEM stage. It produces the MEM_RegWrite/MEM_WriteRegister and WB_RegWrite/WB_WriteRegister pairs consumed by the forwarding unit, plus the matching forward data. When data memory is slow, it freezes the pipeline with a stall handshake. A stuck access can optionally be aborted with a timeout.

## Interface
- DATA_W, 32, width of ALU result, store data and read data
- REG_W, 4, register-address width (16 architectural registers)
- TIMEOUT, 15, WAIT cycles before abort (used only with MEM_TIMEOUT_EN)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg  in  1 each  EX-stage control
- EX_WriteRegister  in  REG_W  EX-stage destination register
- EX_ALUResult  in  DATA_W  ALU result / memory address
- EX_StoreData  in  DATA_W  store operand, already forwarded
- Flush  in  1  load a bubble into EX/MEM instead of EX inputs
- MemReady  in  1  data memory completes the current access this cycle
- MemReadData  in  DATA_W  load data, valid when MemReady=1
- MemRead, MemWrite  out  1 each  data-memory request, held until completed
- MemAddress, MemStoreData  out  DATA_W  request address/data (EX/MEM copies)
- MEM_RegWrite  out  1;  MEM_WriteRegister  out  REG_W;  MEM_ALUResult  out  DATA_W  EX/MEM contents
- WB_RegWrite  out  1;  WB_WriteRegister  out  REG_W;  WB_WriteData  out  DATA_W  MEM/WB contents; WB_WriteData is already muxed (load data or ALU result)
- PipeStall  out  1  freeze PC, IF/ID, ID/EX
- MemError  out  1  one-cycle abort pulse (0 when MEM_TIMEOUT_EN is undefined)

## Operation
- EX/MEM register: at each edge with PipeStall=0, it captures the EX inputs. If Flush=1, it captures a bubble instead (all control bits 0, data 0). Flush takes priority over the EX inputs.
- MemRead = MEM-stage MemRead; MemWrite = MEM-stage MemWrite. Both are combinational from EX/MEM and are never both 1 (EX guarantees this).
- MEM/WB register: at each edge with PipeStall=0, it captures RegWrite, WriteRegister and data. Data is MemReadData if MemToReg=1, else ALU result.
- WriteRegister 0 passes through unmodified; the forwarding unit and register file ignore it.
- FSM states:
  - RUN: PipeStall = (MemRead|MemWrite) & ~MemReady. If PipeStall=1, go to WAIT and set counter=1.
  - WAIT: PipeStall = ~MemReady. If MemReady=1, capture into MEM/WB and go to RUN (counter=0). Otherwise counter+1, saturating at 2^5-1.
- During a stall, both registers hold their values. WB_RegWrite stays asserted, so the register file rewrite is idempotent. Flush is ignored while PipeStall=1.

## Timing
- Reset (synchronous): all control outputs 0, all data/address outputs 0, state RUN, counter 0, MemError 0, PipeStall 0.
- Latency: EX inputs at edge N appear on MEM_* in cycle N+1 and on WB_* in cycle N+2, provided there is no stall.
- Single-cycle memory (MemReady=1 in the request cycle): no stall, no WAIT state.
- The request is held constant from its first cycle until the edge at which MemReady=1. Memory must complete each request exactly once.
- PipeStall is combinational on MemReady in the same cycle.
- Reset during WAIT abandons the access. MemRead/MemWrite are 0 from the cycle after the reset edge.
- MemReady=1 with no request pending is ignored.

## Configuration
- MEM_TIMEOUT_EN defined:
  - In WAIT with counter==TIMEOUT and MemReady=0: MemError=1 and PipeStall=0 for that cycle.
  - MEM/WB then captures with RegWrite forced to 0, and the state returns to RUN.
  - A load therefore produces no register write, and a store is dropped.
- MEM_TIMEOUT_EN undefined: WAIT persists until MemReady. MemError is tied 0 and the counter logic is removed.

## Test plan
- ALU op (EX_RegWrite=1, reg 5, result 0x1234), no memory op → MEM_RegWrite=1/reg 5 next cycle, WB_WriteData=0x1234 the cycle after, PipeStall never 1.
- Load reg 3 addr 0x40, MemReady low 3 cycles then high with 0xCAFE → PipeStall=1 exactly 3 cycles; EX/MEM and WB outputs frozen; WB reg 3 = 0xCAFE one edge after MemReady.
- Flush=1 alongside a valid EX store → MemWrite stays 0 next cycle, MEM_RegWrite=0.
- Flush=1 during a stall → ignored; the pending load completes normally.
- Reset asserted in WAIT → next cycle all outputs 0, PipeStall=0, state RUN.
- MEM_TIMEOUT_EN, TIMEOUT=15, MemReady held 0 → MemError pulses in the 15th WAIT cycle, PipeStall drops, WB_RegWrite=0 for that instruction.

Source files
------------

// File: rtl/mem_wb_pipeline.sv
// mem_wb_pipeline: EX/MEM and MEM/WB pipeline registers plus the MEM-stage
// data-memory access sequencer.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   EX_*                  EX-stage control, destination register, ALU result, store data
//   Flush                 load a bubble into EX/MEM instead of the EX inputs
//   MemReady, MemReadData memory completion strobe and load data
//   MemRead, MemWrite     memory request, held until completed
//   MemAddress, MemStoreData  request address/data (EX/MEM copies)
//   MEM_*                 EX/MEM contents for the forwarding unit
//   WB_*                  MEM/WB contents; WB_WriteData already muxed (load data or ALU result)
//   PipeStall             freeze PC, IF/ID, ID/EX while memory is busy
//   MemError              one-cycle pulse when a stuck access is aborted
//
// Build option: define MEM_TIMEOUT_EN to abort an access after TIMEOUT WAIT cycles.
// Without it the access waits indefinitely and MemError is tied 0.
module mem_wb_pipeline #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_W   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              EX_RegWrite,
  input  logic              EX_MemRead,
  input  logic              EX_MemWrite,
  input  logic              EX_MemToReg,
  input  logic [REG_W-1:0]  EX_WriteRegister,
  input  logic [DATA_W-1:0] EX_ALUResult,
  input  logic [DATA_W-1:0] EX_StoreData,
  input  logic              Flush,
  input  logic              MemReady,
  input  logic [DATA_W-1:0] MemReadData,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [DATA_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemStoreData,
  output logic              MEM_RegWrite,
  output logic [REG_W-1:0]  MEM_WriteRegister,
  output logic [DATA_W-1:0] MEM_ALUResult,
  output logic              WB_RegWrite,
  output logic [REG_W-1:0]  WB_WriteRegister,
  output logic [DATA_W-1:0] WB_WriteData,
  output logic              PipeStall,
  output logic              MemError
);

  typedef enum logic [0:0] {StRun, StWait} stateT;

  stateT stateQ, stateD;

  // EX/MEM register
  logic              memRegWriteQ, memMemReadQ, memMemWriteQ, memMemToRegQ;
  logic [REG_W-1:0]  memWriteRegQ;
  logic [DATA_W-1:0] memAluResultQ, memStoreDataQ;

  // MEM/WB register
  logic              wbRegWriteQ;
  logic [REG_W-1:0]  wbWriteRegQ;
  logic [DATA_W-1:0] wbWriteDataQ;

  logic memReq, pipeStall, memError;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = 5;
  logic [CntW-1:0] cntQ, cntD;
`else
  logic unusedTimeout;
  assign unusedTimeout = ^TIMEOUT;
`endif

  assign memReq = memMemReadQ | memMemWriteQ;

  always_comb begin
    stateD    = stateQ;
    pipeStall = 1'b0;
    memError  = 1'b0;
    unique case (stateQ)
      StRun: begin
        pipeStall = memReq & ~MemReady;
        if (pipeStall) stateD = StWait;
      end
      StWait: begin
        pipeStall = ~MemReady;
        if (MemReady) begin
          stateD = StRun;
`ifdef MEM_TIMEOUT_EN
        end else if (cntQ == CntW'(TIMEOUT)) begin
          // Abort: let the pipeline advance with the write suppressed.
          pipeStall = 1'b0;
          memError  = 1'b1;
          stateD    = StRun;
`endif
        end
      end
      default: stateD = StRun;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  // Counts WAIT cycles: 1 in the first WAIT cycle, saturating at all-ones.
  always_comb begin
    cntD = cntQ;
    if (stateQ == StRun) begin
      cntD = pipeStall ? CntW'(1) : '0;
    end else if (stateD == StRun) begin
      cntD = '0;
    end else if (cntQ != '1) begin
      cntD = cntQ + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cntQ <= '0;
    else       cntQ <= cntD;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ        <= StRun;
      memRegWriteQ  <= 1'b0;
      memMemReadQ   <= 1'b0;
      memMemWriteQ  <= 1'b0;
      memMemToRegQ  <= 1'b0;
      memWriteRegQ  <= '0;
      memAluResultQ <= '0;
      memStoreDataQ <= '0;
      wbRegWriteQ   <= 1'b0;
      wbWriteRegQ   <= '0;
      wbWriteDataQ  <= '0;
    end else begin
      stateQ <= stateD;
      if (!pipeStall) begin
        if (Flush) begin
          memRegWriteQ  <= 1'b0;
          memMemReadQ   <= 1'b0;
          memMemWriteQ  <= 1'b0;
          memMemToRegQ  <= 1'b0;
          memWriteRegQ  <= '0;
          memAluResultQ <= '0;
          memStoreDataQ <= '0;
        end else begin
          memRegWriteQ  <= EX_RegWrite;
          memMemReadQ   <= EX_MemRead;
          memMemWriteQ  <= EX_MemWrite;
          memMemToRegQ  <= EX_MemToReg;
          memWriteRegQ  <= EX_WriteRegister;
          memAluResultQ <= EX_ALUResult;
          memStoreDataQ <= EX_StoreData;
        end
        wbRegWriteQ  <= memRegWriteQ & ~memError;
        wbWriteRegQ  <= memWriteRegQ;
        wbWriteDataQ <= memMemToRegQ ? MemReadData : memAluResultQ;
      end
    end
  end

  assign MemRead           = memMemReadQ;
  assign MemWrite          = memMemWriteQ;
  assign MemAddress        = memAluResultQ;
  assign MemStoreData      = memStoreDataQ;
  assign MEM_RegWrite      = memRegWriteQ;
  assign MEM_WriteRegister = memWriteRegQ;
  assign MEM_ALUResult     = memAluResultQ;
  assign WB_RegWrite       = wbRegWriteQ;
  assign WB_WriteRegister  = wbWriteRegQ;
  assign WB_WriteData      = wbWriteDataQ;
  assign PipeStall         = pipeStall;
  assign MemError          = memError;

endmodule

// File: tb/tb_mem_wb_pipeline.sv
module tb_mem_wb_pipeline;

  localparam int unsigned TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        exRw, exMr, exMw, exM2r;
  logic [3:0]  exReg;
  logic [31:0] exAlu, exSd;
  logic        Flush, MemReady;
  logic [31:0] MemReadData;
  logic        MemRead, MemWrite, MEM_RegWrite, WB_RegWrite, PipeStall, MemError;
  logic [31:0] MemAddress, MemStoreData, MEM_ALUResult, WB_WriteData;
  logic [3:0]  MEM_WriteRegister, WB_WriteRegister;

  always #5 clk = ~clk;

  mem_wb_pipeline #(.DATA_W(32), .REG_W(4), .TIMEOUT(TIMEOUT)) dut (
    .clk               (clk),
    .reset             (reset),
    .EX_RegWrite       (exRw),
    .EX_MemRead        (exMr),
    .EX_MemWrite       (exMw),
    .EX_MemToReg       (exM2r),
    .EX_WriteRegister  (exReg),
    .EX_ALUResult      (exAlu),
    .EX_StoreData      (exSd),
    .Flush             (Flush),
    .MemReady          (MemReady),
    .MemReadData       (MemReadData),
    .MemRead           (MemRead),
    .MemWrite          (MemWrite),
    .MemAddress        (MemAddress),
    .MemStoreData      (MemStoreData),
    .MEM_RegWrite      (MEM_RegWrite),
    .MEM_WriteRegister (MEM_WriteRegister),
    .MEM_ALUResult     (MEM_ALUResult),
    .WB_RegWrite       (WB_RegWrite),
    .WB_WriteRegister  (WB_WriteRegister),
    .WB_WriteData      (WB_WriteData),
    .PipeStall         (PipeStall),
    .MemError          (MemError)
  );

  typedef struct packed {
    logic        rw, mr, mw, m2r;
    logic [3:0]  wreg;
    logic [31:0] alu, sd;
  } itemT;

  typedef struct packed {
    logic        rw;
    logic [3:0]  wreg;
    logic [31:0] data;
  } wbT;

  // Instructions issued into EX/MEM; the head is the one currently in MEM.
  itemT pipeQ[$];
  wbT   wbExp;
  int   waitCnt;
  int   assertCnt = 0;
  int   failCnt   = 0;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCnt++;
    if (got !== exp) begin
      failCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic setEx(input logic rw, input logic mr, input logic mw, input logic m2r,
                       input logic [3:0] wreg, input logic [31:0] alu, input logic [31:0] sd);
    exRw = rw; exMr = mr; exMw = mw; exM2r = m2r; exReg = wreg; exAlu = alu; exSd = sd;
  endtask

  task automatic bubble();
    setEx(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  // One clock cycle: drive, check outputs at the falling edge, then advance the model.
  task automatic cyc(input logic rst, input logic fl, input logic rdy, input logic [31:0] rd);
    itemT slot, nxt;
    logic expStall, expErr;
    reset = rst; Flush = fl; MemReady = rdy; MemReadData = rd;
    slot     = pipeQ[0];
    expStall = (slot.mr | slot.mw) & ~rdy;
    expErr   = 1'b0;
`ifdef MEM_TIMEOUT_EN
    if (expStall && waitCnt == TIMEOUT) begin
      expStall = 1'b0;
      expErr   = 1'b1;
    end
`endif
    @(negedge clk);
    checkEq("PipeStall", 32'(PipeStall), 32'(expStall));
    checkEq("MemError", 32'(MemError), 32'(expErr));
    checkEq("MemRead", 32'(MemRead), 32'(slot.mr));
    checkEq("MemWrite", 32'(MemWrite), 32'(slot.mw));
    checkEq("MemAddress", MemAddress, slot.alu);
    checkEq("MemStoreData", MemStoreData, slot.sd);
    checkEq("MEM_RegWrite", 32'(MEM_RegWrite), 32'(slot.rw));
    checkEq("MEM_WriteRegister", 32'(MEM_WriteRegister), 32'(slot.wreg));
    checkEq("MEM_ALUResult", MEM_ALUResult, slot.alu);
    checkEq("WB_RegWrite", 32'(WB_RegWrite), 32'(wbExp.rw));
    checkEq("WB_WriteRegister", 32'(WB_WriteRegister), 32'(wbExp.wreg));
    checkEq("WB_WriteData", WB_WriteData, wbExp.data);
    @(posedge clk);
    if (rst) begin
      pipeQ.delete();
      pipeQ.push_back('0);
      wbExp   = '0;
      waitCnt = 0;
    end else if (!expStall) begin
      slot  = pipeQ.pop_front();
      wbExp = '{rw: slot.rw & ~expErr, wreg: slot.wreg, data: slot.m2r ? rd : slot.alu};
      nxt   = fl ? '0 : '{rw: exRw, mr: exMr, mw: exMw, m2r: exM2r, wreg: exReg,
                          alu: exAlu, sd: exSd};
      pipeQ.push_back(nxt);
      waitCnt = 0;
    end else if (waitCnt < 31) begin
      waitCnt++;
    end
    #1;
  endtask

  initial begin
    int op;
    bubble();
    reset = 1'b1; Flush = 1'b0; MemReady = 1'b0; MemReadData = '0;
    pipeQ.push_back('0);
    wbExp   = '0;
    waitCnt = 0;
    @(posedge clk); #1;

    // Reset state
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);

    // Plain ALU op to reg 5
    setEx(1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 32'h1234, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    bubble();
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 32'd0);

    // Load reg 3 from 0x40, memory slow for 3 cycles; EX inputs wiggle during the stall
    setEx(1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 32'h40, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    setEx(1'b1, 1'b0, 1'b0, 1'b0, 4'd7, 32'h77, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'h1111);
    setEx(1'b1, 1'b0, 1'b0, 1'b0, 4'd8, 32'h88, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'h2222);
    cyc(1'b0, 1'b0, 1'b0, 32'h3333);
    cyc(1'b0, 1'b0, 1'b1, 32'hCAFE);
    bubble();
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 32'd0);

    // Flush alongside a store
    setEx(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 32'h80, 32'hDEAD);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    bubble();
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 32'd0);

    // Flush during a stall is ignored
    setEx(1'b1, 1'b1, 1'b0, 1'b1, 4'd9, 32'h44, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    setEx(1'b1, 1'b0, 1'b0, 1'b0, 4'd10, 32'hA0, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 32'hBEEF);
    bubble();
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 32'd0);

    // Single-cycle store, then MemReady with nothing pending; reg 0 passes through
    setEx(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 32'h90, 32'h55);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    setEx(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0F0F, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 32'd0);
    bubble();
    cyc(1'b0, 1'b0, 1'b1, 32'h1);
    cyc(1'b0, 1'b0, 1'b1, 32'h2);

    // Reset while waiting on memory
    setEx(1'b1, 1'b1, 1'b0, 1'b1, 4'd4, 32'h48, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    bubble();
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 32'd0);

`ifdef MEM_TIMEOUT_EN
    // Stuck load aborts in the TIMEOUT-th WAIT cycle
    setEx(1'b1, 1'b1, 1'b0, 1'b1, 4'd6, 32'h4C, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    bubble();
    repeat (TIMEOUT + 3) cyc(1'b0, 1'b0, 1'b0, 32'hBAD);
`endif

    // Random mix of ALU ops, loads, stores, flushes and memory latencies
    for (int i = 0; i < 80; i++) begin
      op = int'($urandom_range(0, 3));
      case (op)
        1: setEx(1'b1, 1'b0, 1'b0, 1'b0, 4'($urandom), $urandom, $urandom);
        2: setEx(1'b1, 1'b1, 1'b0, 1'b1, 4'($urandom), $urandom, $urandom);
        3: setEx(1'b0, 1'b0, 1'b1, 1'b0, 4'($urandom), $urandom, $urandom);
        default: bubble();
      endcase
      cyc(1'b0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) != 0), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule
